// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and a global stall.
// Optional feature: define PPA_SATURATE_EN to clamp signed-overflow results to the signed limit.
module pipelined_prefix_adder #(
  parameter int WIDTH       = 10,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  // Position 0 of the prefix vectors carries cin_eff; position i+1 is operand bit i.
  localparam int N = WIDTH + 1;
  localparam int L = $clog2(N);

  // A level is followed by a pipeline register when it equals floor(k*L/PIPE_STAGES).
  function automatic bit is_cut(input int lvl);
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if ((k * L) / PIPE_STAGES == lvl) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // c*: combinational output of each level; s*: same after an optional stage register.
  logic [N-1:0]     cg [0:L];
  logic [N-1:0]     cp [0:L];
  logic [N-1:0]     sg [0:L];
  logic [N-1:0]     sp [0:L];
  logic [WIDTH-1:0] cb [0:L];
  logic [WIDTH-1:0] sb [0:L];
  logic             cv [0:L];
  logic             sv [0:L];

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = op_sub ? ~b : b;
  assign cin_eff = op_sub ? ~c_in : c_in;

  assign cg[0] = {a & b_eff, cin_eff};
  assign cp[0] = {a ^ b_eff, 1'b0};
  assign cb[0] = a ^ b_eff;
  assign cv[0] = in_valid;

  for (genvar j = 0; j <= L; j++) begin : g_lvl
    if (j > 0) begin : g_comb
      localparam int D = 1 << (j - 1);
      // Zero-fill below D is exact: any group reaching position 0 has P = 0 there.
      assign cg[j] = sg[j-1] | (sp[j-1] & (sg[j-1] << D));
      assign cp[j] = sp[j-1] & (sp[j-1] << D);
      assign cb[j] = sb[j-1];
      assign cv[j] = sv[j-1];
    end

    if (is_cut(j)) begin : g_cut
      logic [N-1:0]     rg, rp;
      logic [WIDTH-1:0] rb;
      logic             rv;

      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of process evaluation order.
      always_ff @(posedge clk) begin
        if (!rst_n)       rv <= 1'b0;
        else if (advance) rv <= cv[j];
      end

      // NOTE: stage data is deliberately not reset; the valid bit alone qualifies it.
      always_ff @(posedge clk) begin
        if (advance) begin
          rg <= cg[j];
          rp <= cp[j];
          rb <= cb[j];
        end
      end

      assign sg[j] = rg;
      assign sp[j] = rp;
      assign sb[j] = rb;
      assign sv[j] = rv;
    end else begin : g_pass
      assign sg[j] = cg[j];
      assign sp[j] = cp[j];
      assign sb[j] = cb[j];
      assign sv[j] = cv[j];
    end
  end

  // After the last level, sg[L][i] is the carry into operand bit i.
  logic [N-1:0]     carry;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] res_sum;
  logic             res_c;
  logic             res_ovf;

  assign carry   = sg[L];
  assign raw_sum = sb[L] ^ carry[WIDTH-1:0];
  assign res_c   = carry[WIDTH];
  assign res_ovf = carry[WIDTH-1] ^ carry[WIDTH];

`ifdef PPA_SATURATE_EN
  // On overflow the wrapped sign is the inverse of a's sign, so it selects the limit.
  assign res_sum = res_ovf ? (raw_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                               : {1'b1, {(WIDTH-1){1'b0}}})
                           : raw_sum;
`else
  assign res_sum = raw_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= sv[L];
      if (sv[L]) begin
        sum   <= res_sum;
        c_out <= res_c;
        ovf   <= res_ovf;
        zero  <= ~|res_sum;
      end
    end
  end

endmodule
